// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer RAM arbiter: FSM encoding,
// default geometry for a 160x120 RGB111 buffer and fill colours.
package fb_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // 160x120 = 19200 pixels fits in 2**15 words of RGB111
    localparam int FB_AW = 15;
    localparam int FB_DW = 3;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/fb_ram_arb_if.sv
// Bus between the frame-buffer RAM and its users: NW packed write
// ports with req/ack, one registered read port and the clear-busy flag.
// master = writers/reader side, slave = the RAM arbiter.
interface fb_ram_arb_if #(
    parameter int AW = 15,
    parameter int DW = 3,
    parameter int NW = 2
);
    logic [NW-1:0]    wr_req;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]    wr_ack;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             busy;

    modport master (
        output wr_req, wr_addr, wr_data, rd_addr,
        input  wr_ack, rd_data, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_addr,
        output wr_ack, rd_data, busy
    );
endinterface

// File: rtl/fb_ram_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr.
// Ports: req (N), ptr (last winner) -> grant (one-hot), grant_idx.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW:0]    base;
    logic [IW:0]    sum;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           hit;

    always_comb begin
        base      = {1'b0, ptr} + (IW+1)'(1);
        // rot[j] is the request of port (ptr+1+j) mod N
        dbl       = {req, req} >> base;
        rot       = dbl[N-1:0];
        sum       = '0;
        hit       = 1'b0;
        grant_idx = ptr;
        for (int j = 0; j < N; j++) begin
            sum = base + (IW+1)'(j);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!hit && rot[j]) begin
                hit       = 1'b1;
                grant_idx = sum[IW-1:0];
            end
        end
        grant = hit ? (N'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/fb_ram_arb.sv
// Frame-buffer RAM with NW round-robin write ports, one registered
// read-first read port and an optional post-reset clear sweep.
// Ports: clk, reset (sync, active-high), bus (fb_ram_arb_if.slave).
module fb_ram_arb
    import fb_pkg::*;
#(
    parameter int          AW        = FB_AW,
    parameter int          DW        = FB_DW,
    parameter int          NW        = 2,
    parameter int          CLEAR_EN  = 1,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input logic         clk,
    input logic         reset,
    fb_ram_arb_if.slave bus
);
    localparam int NPOS = 2 ** AW;
    localparam int IW   = (NW > 1) ? $clog2(NW) : 1;

    logic [DW-1:0] ram [NPOS];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [NW-1:0] req_ok;
    logic [NW-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    // no grants while clearing or in the reset cycle itself
    assign req_ok = (state_q == ST_RUN && !reset) ? bus.wr_req : '0;

    rr_arbiter #(.N(NW), .IW(IW)) u_arb (
        .req       (req_ok),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.wr_ack  = grant;
    assign bus.busy    = (state_q == ST_CLEAR);
    assign bus.rd_data = rd_data_q;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NW; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_addr = bus.wr_addr[i*AW +: AW];
                sel_data = bus.wr_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        we        = 1'b0;
        waddr     = sel_addr;
        wdata     = sel_data;
        if (state_q == ST_CLEAR) begin
            we        = !reset;
            waddr     = clr_cnt_q;
            wdata     = CLEAR_VAL;
            clr_cnt_d = clr_cnt_q + AW'(1);
            // counter wraps to 0 exactly as the sweep ends
            if (&clr_cnt_q) begin
                state_d = ST_RUN;
            end
        end else if (|grant) begin
            we       = 1'b1;
            rr_ptr_d = grant_idx;
        end
        // read-first: sampled before this edge's write lands
        rd_data_d = ram[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            rr_ptr_q  <= IW'(NW - 1);
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // array kept free of reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end
endmodule
